// File: rtl/multi_operand_accumulator.sv
// Sequential multi-operand adder: sums a group of up to N_OPS operands (each with carry-in)
// delivered over a valid/ready stream and presents one registered result word per group.
module multi_operand_accumulator #(
    parameter int unsigned RES   = 4,
    parameter int unsigned N_OPS = 8,
    parameter int unsigned OUT_W = 7,
    parameter int unsigned SAT   = 1,
    localparam int unsigned ACC_W = RES + $clog2(N_OPS) + 1,
    localparam int unsigned CNT_W = $clog2(N_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES-1:0]   a,
    input  logic             cin,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic               accept_c;
    logic               close_c;
    logic [ACC_W-1:0]   sum_c;
    logic [CNT_W-1:0]   cnt_next_c;
    logic               ovf_c;
    logic [OUT_W-1:0]   out_c;

    // Ready drops combinationally during reset so nothing is taken while rst is high.
    assign in_ready  = !rst && (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept_c  = in_valid && in_ready;

    // Running sum and count including the operand on the inputs; IDLE starts from zero.
    always_comb begin
        sum_c      = ((state == IDLE) ? '0 : acc) + ACC_W'(a) + ACC_W'(cin);
        cnt_next_c = ((state == IDLE) ? '0 : cnt) + CNT_W'(1);
        close_c    = accept_c && (last || (cnt_next_c == CNT_W'(N_OPS)));
        ovf_c      = (sum_c > OUT_MAX);
        out_c      = sum_c[OUT_W-1:0];
        if ((SAT != 0) && ovf_c) begin
            out_c = {OUT_W{1'b1}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: begin
                if (close_c) begin
                    state_next = HOLD;
                end else if (accept_c) begin
                    state_next = ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result fields are captured on the closing accept and held until the next close or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (close_c) begin
            acc   <= '0;
            cnt   <= '0;
            out   <= out_c;
            ovf   <= ovf_c;
            count <= cnt_next_c;
        end else if (accept_c) begin
            acc   <= sum_c;
            cnt   <= cnt_next_c;
        end
    end

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench for multi_operand_accumulator; a saturating and a wrapping instance
// share one input stream so both result modes are checked from the same groups.
module tb_multi_operand_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic       cin;
    logic       last;
    logic       out_ready;

    logic       ready_s, valid_s, ovf_s;
    logic [6:0] out_s;
    logic [3:0] count_s;
    logic       ready_w, valid_w, ovf_w;
    logic [6:0] out_w;
    logic [3:0] count_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_operand_accumulator #(.RES(4), .N_OPS(8), .OUT_W(7), .SAT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_s),
        .a(a), .cin(cin), .last(last), .out_valid(valid_s), .out_ready(out_ready),
        .out(out_s), .ovf(ovf_s), .count(count_s)
    );

    multi_operand_accumulator #(.RES(4), .N_OPS(8), .OUT_W(7), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_w),
        .a(a), .cin(cin), .last(last), .out_valid(valid_w), .out_ready(out_ready),
        .out(out_w), .ovf(ovf_w), .count(count_w)
    );

    // Present one operand; it is accepted on the next rising edge (callers ensure ready).
    task automatic send(input logic [3:0] av, input logic c, input logic l);
        in_valid = 1'b1; a = av; cin = c; last = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = '0; cin = 1'b0; last = 1'b0;
    endtask

    // Cycles from the final accept until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_s && lat < 20);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = '0; cin = 1'b0; last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready_s !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 0", ready_s); end
        n_checks++; if (valid_s !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", valid_s); end
        n_checks++; if (out_s !== 7'd0 || ovf_s !== 1'b0 || count_s !== 4'd0) begin
            n_fail++; $display("FAIL reset_fields: got out=%0d ovf=%0b count=%0d expected 0/0/0", out_s, ovf_s, count_s); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if (ready_s !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b expected 1", ready_s); end
    endtask

    task automatic test_full_group();
        int lat;
        for (int i = 0; i < 7; i++) send(4'd15, 1'b0, 1'b0);
        n_checks++; if (valid_s !== 1'b0 || ready_s !== 1'b1) begin
            n_fail++; $display("FAIL full_pre_close: got valid=%0b ready=%0b expected 0/1", valid_s, ready_s); end
        send(4'd15, 1'b0, 1'b0);
        wait_valid(lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL full_latency: got %0d expected 1", lat); end
        n_checks++; if (out_s !== 7'd120 || ovf_s !== 1'b0 || count_s !== 4'd8) begin
            n_fail++; $display("FAIL full_result: got out=%0d ovf=%0b count=%0d expected 120/0/8", out_s, ovf_s, count_s); end
        n_checks++; if (out_w !== 7'd120) begin n_fail++; $display("FAIL full_wrap_out: got %0d expected 120", out_w); end
        repeat (2) @(negedge clk);
        n_checks++; if (ready_s !== 1'b0 || valid_s !== 1'b1) begin
            n_fail++; $display("FAIL full_hold: got ready=%0b valid=%0b expected 0/1", ready_s, valid_s); end
        handshake();
        @(negedge clk);
        n_checks++; if (valid_s !== 1'b0 || ready_s !== 1'b1) begin
            n_fail++; $display("FAIL full_release: got valid=%0b ready=%0b expected 0/1", valid_s, ready_s); end
    endtask

    task automatic test_overflow();
        int lat;
        for (int i = 0; i < 8; i++) send(4'd15, 1'b1, 1'b0);
        wait_valid(lat);
        n_checks++; if (out_s !== 7'd127 || ovf_s !== 1'b1 || count_s !== 4'd8) begin
            n_fail++; $display("FAIL ovf_sat: got out=%0d ovf=%0b count=%0d expected 127/1/8", out_s, ovf_s, count_s); end
        n_checks++; if (out_w !== 7'd0 || ovf_w !== 1'b1 || count_w !== 4'd8 || valid_w !== 1'b1) begin
            n_fail++; $display("FAIL ovf_wrap: got out=%0d ovf=%0b count=%0d valid=%0b expected 0/1/8/1", out_w, ovf_w, count_w, valid_w); end
        handshake();
        @(negedge clk);
        n_checks++; if (ready_w !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_ready: got %0b expected 1", ready_w); end
    endtask

    task automatic test_early_last();
        int lat;
        send(4'd1, 1'b1, 1'b0);
        send(4'd2, 1'b0, 1'b0);
        send(4'd3, 1'b0, 1'b1);
        wait_valid(lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL last_latency: got %0d expected 1", lat); end
        n_checks++; if (out_s !== 7'd7 || ovf_s !== 1'b0 || count_s !== 4'd3) begin
            n_fail++; $display("FAIL last_result: got out=%0d ovf=%0b count=%0d expected 7/0/3", out_s, ovf_s, count_s); end
        handshake();
        send(4'd5, 1'b0, 1'b1);
        wait_valid(lat);
        n_checks++; if (out_s !== 7'd5 || count_s !== 4'd1) begin
            n_fail++; $display("FAIL single_result: got out=%0d count=%0d expected 5/1", out_s, count_s); end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        for (int i = 0; i < 8; i++) send(4'd2, 1'b0, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; a = 4'd7; last = 1'b1;
            @(negedge clk);
            n_checks++; if (out_s !== 7'd16 || ready_s !== 1'b0 || valid_s !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold_%0d: got out=%0d ready=%0b valid=%0b expected 16/0/1", i, out_s, ready_s, valid_s); end
        end
        in_valid = 1'b0; a = '0; last = 1'b0;
        handshake();
        @(negedge clk);
        n_checks++; if (ready_s !== 1'b1 || valid_s !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got ready=%0b valid=%0b expected 1/0", ready_s, valid_s); end
        send(4'd3, 1'b0, 1'b1);
        wait_valid(lat);
        n_checks++; if (out_s !== 7'd3 || count_s !== 4'd1) begin
            n_fail++; $display("FAIL bp_no_absorb: got out=%0d count=%0d expected 3/1", out_s, count_s); end
        handshake();
    endtask

    task automatic test_reset_mid_group();
        int lat;
        for (int i = 0; i < 4; i++) send(4'd9, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (valid_s !== 1'b0 || count_s !== 4'd0 || out_s !== 7'd0 || ready_s !== 1'b1) begin
            n_fail++; $display("FAIL midrst_state: got valid=%0b count=%0d out=%0d ready=%0b expected 0/0/0/1", valid_s, count_s, out_s, ready_s); end
        for (int i = 0; i < 8; i++) send(4'd1, 1'b0, 1'b0);
        wait_valid(lat);
        n_checks++; if (out_s !== 7'd8 || count_s !== 4'd8) begin
            n_fail++; $display("FAIL midrst_next: got out=%0d count=%0d expected 8/8", out_s, count_s); end
        handshake();
    endtask

    task automatic test_bubbles();
        int lat_b2b;
        int lat_bub;
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0, 1'b0);
        wait_valid(lat_b2b);
        n_checks++; if (out_s !== 7'd36 || count_s !== 4'd8 || lat_b2b !== 1) begin
            n_fail++; $display("FAIL b2b_result: got out=%0d count=%0d lat=%0d expected 36/8/1", out_s, count_s, lat_b2b); end
        handshake();
        for (int i = 1; i <= 8; i++) begin
            send(4'(i), 1'b0, 1'b0);
            if (i < 8) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                n_checks++; if (valid_s !== 1'b0) begin n_fail++; $display("FAIL bubble_early_valid_%0d: got %0b expected 0", i, valid_s); end
            end
        end
        wait_valid(lat_bub);
        n_checks++; if (out_s !== 7'd36 || count_s !== 4'd8 || lat_bub !== lat_b2b) begin
            n_fail++; $display("FAIL bubble_result: got out=%0d count=%0d lat=%0d expected 36/8/%0d", out_s, count_s, lat_bub, lat_b2b); end
        handshake();
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_overflow();
        test_early_last();
        test_backpressure();
        test_reset_mid_group();
        test_bubbles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
